key_conditioner: RTL and testbench

- Multi-channel push-button conditioner replacing the fixed single-timer debounce in the DE2-115 game top.
- Each of N_KEYS active-low KEY inputs gets synchronised, debounced and converted into level and single-cycle event outputs: press, release, long-press and auto-repeat.
- Sits between the board KEY pins and the game FSM. Timing parameters are overridden to small values in simulation, the same way as SIM_DEBOUNCE_TIMER.

---
 rtl/key_conditioner_pkg.sv | 24 ++
 rtl/key_conditioner_if.sv | 27 ++
 rtl/key_channel.sv | 150 +++++++++++++++
 rtl/key_conditioner.sv | 51 +++++
 tb/tb_key_conditioner.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/key_conditioner_pkg.sv
// key_pkg: shared types and timing constants for the push-button conditioner.
//   key_state_e      : per-channel state (IDLE, HELD, LONG)
//   *_BOARD          : 50 MHz board timing (20 ms debounce, 1 s hold, 200 ms repeat)
//   *_SIM            : small values used when simulating
package key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } key_state_e;

  localparam int DB_W   = 20;
  localparam int HOLD_W = 27;

  localparam logic [DB_W-1:0]   DEBOUNCE_CYCLES_BOARD = 20'd1000000;
  localparam logic [HOLD_W-1:0] HOLD_CYCLES_BOARD     = 27'd50000000;
  localparam logic [HOLD_W-1:0] REPEAT_CYCLES_BOARD   = 27'd10000000;

  localparam logic [DB_W-1:0]   DEBOUNCE_CYCLES_SIM   = 20'd5;
  localparam logic [HOLD_W-1:0] HOLD_CYCLES_SIM       = 27'd20;
  localparam logic [HOLD_W-1:0] REPEAT_CYCLES_SIM     = 27'd8;

endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: groups the per-channel key inputs and event outputs.
//   key_n     : raw active-low buttons (asynchronous)
//   repeat_en : per-channel auto-repeat enable
//   pressed   : debounced level, 1 = held
//   press_p / release_p / long_p / repeat_p : single-cycle event pulses
// master drives the keys (board / bench), slave is the conditioner.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] repeat_en;
  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] press_p;
  logic [N_KEYS-1:0] release_p;
  logic [N_KEYS-1:0] long_p;
  logic [N_KEYS-1:0] repeat_p;

  modport master (
    output key_n, repeat_en,
    input  pressed, press_p, release_p, long_p, repeat_p
  );

  modport slave (
    input  key_n, repeat_en,
    output pressed, press_p, release_p, long_p, repeat_p
  );
endinterface

// File: rtl/key_channel.sv
// key_channel: one button channel.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_key_n        : raw active-low button
//   i_repeat_en    : auto-repeat enable
//   o_pressed      : debounced level
//   o_press_p, o_release_p, o_long_p, o_repeat_p : registered one-cycle events
// Two-flop synchroniser -> debounce counter -> IDLE/HELD/LONG FSM with a
// shared hold/repeat counter.
module key_channel
  import key_pkg::*;
#(
  parameter logic [DB_W-1:0]   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
  parameter logic [HOLD_W-1:0] HOLD_CYCLES     = HOLD_CYCLES_BOARD,
  parameter logic [HOLD_W-1:0] REPEAT_CYCLES   = REPEAT_CYCLES_BOARD,
  parameter int                CNT_W           = 27
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  input  logic i_repeat_en,
  output logic o_pressed,
  output logic o_press_p,
  output logic o_release_p,
  output logic o_long_p,
  output logic o_repeat_p
);

  localparam logic [DB_W-1:0]  DB_M1   = DEBOUNCE_CYCLES - DB_W'(1);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - HOLD_W'(1));
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYCLES - HOLD_W'(1));

  logic            r_sync1;
  logic            r_sync2;
  logic            w_s;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_pressed;
  logic            w_toggle;
  logic            w_acc_press;
  logic            w_acc_rel;

  key_state_e      r_state;
  key_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic            r_press_p;
  logic            r_release_p;
  logic            r_long_p;
  logic            r_repeat_p;
  logic            w_long_nxt;
  logic            w_repeat_nxt;

  // Synchroniser resets to the released level so no spurious press at start-up.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s         = ~r_sync2;
  assign w_toggle    = (w_s != r_pressed) && (r_db_cnt == DB_M1);
  assign w_acc_press = w_toggle & ~r_pressed;
  assign w_acc_rel   = w_toggle &  r_pressed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db_cnt  <= '0;
      r_pressed <= 1'b0;
    end else if (w_s == r_pressed) begin
      r_db_cnt  <= '0;
    end else if (w_toggle) begin
      r_db_cnt  <= '0;
      r_pressed <= ~r_pressed;
    end else begin
      r_db_cnt  <= r_db_cnt + DB_W'(1);
    end
  end

  // Release is checked first so it overrides a coincident long/repeat threshold.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_long_nxt     = 1'b0;
    w_repeat_nxt   = 1'b0;
    if (w_acc_rel) begin
      w_state_nxt    = IDLE;
      w_hold_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc_press) begin
            w_state_nxt    = HELD;
            w_hold_cnt_nxt = '0;
          end
        end
        HELD: begin
          if (r_hold_cnt == HOLD_M1) begin
            w_state_nxt    = LONG;
            w_hold_cnt_nxt = '0;
            w_long_nxt     = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
          end
        end
        LONG: begin
          if (!i_repeat_en) begin
            w_hold_cnt_nxt = '0;
          end else if (r_hold_cnt == REP_M1) begin
            w_hold_cnt_nxt = '0;
            w_repeat_nxt   = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_hold_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_hold_cnt  <= '0;
      r_press_p   <= 1'b0;
      r_release_p <= 1'b0;
      r_long_p    <= 1'b0;
      r_repeat_p  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_press_p   <= w_acc_press;
      r_release_p <= w_acc_rel;
      r_long_p    <= w_long_nxt;
      r_repeat_p  <= w_repeat_nxt;
    end
  end

  assign o_pressed   = r_pressed;
  assign o_press_p   = r_press_p;
  assign o_release_p = r_release_p;
  assign o_long_p    = r_long_p;
  assign o_repeat_p  = r_repeat_p;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: N_KEYS independent push-button conditioners.
//   CLOCK_50 : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : key_conditioner_if slave (key_n, repeat_en in;
//              pressed, press_p, release_p, long_p, repeat_p out)
module key_conditioner
  import key_pkg::*;
#(
  parameter int                N_KEYS          = 4,
  parameter logic [DB_W-1:0]   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
  parameter logic [HOLD_W-1:0] HOLD_CYCLES     = HOLD_CYCLES_BOARD,
  parameter logic [HOLD_W-1:0] REPEAT_CYCLES   = REPEAT_CYCLES_BOARD,
  parameter int                CNT_W           = 27
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  key_conditioner_if.slave  bus
);

  logic [N_KEYS-1:0] w_pressed;
  logic [N_KEYS-1:0] w_press_p;
  logic [N_KEYS-1:0] w_release_p;
  logic [N_KEYS-1:0] w_long_p;
  logic [N_KEYS-1:0] w_repeat_p;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .i_clk       (CLOCK_50),
      .i_rst_n     (reset_n),
      .i_key_n     (bus.key_n[g]),
      .i_repeat_en (bus.repeat_en[g]),
      .o_pressed   (w_pressed[g]),
      .o_press_p   (w_press_p[g]),
      .o_release_p (w_release_p[g]),
      .o_long_p    (w_long_p[g]),
      .o_repeat_p  (w_repeat_p[g])
    );
  end

  assign bus.pressed   = w_pressed;
  assign bus.press_p   = w_press_p;
  assign bus.release_p = w_release_p;
  assign bus.long_p    = w_long_p;
  assign bus.repeat_p  = w_repeat_p;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE=5, HOLD=20, REPEAT=8.
// Expected events are derived from the timing rules when a key is driven and
// queued with the clock edge at which they must appear; a negedge monitor
// compares every cycle's outputs against the due events and a level model.
module tb_key_conditioner;

  localparam int N    = 4;
  localparam int DB   = 5;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int LAT  = 2 + DB;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;
  localparam int EV_REPEAT  = 3;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  ev_t        sb[$];
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [N-1:0] exp_pressed = '0;

  key_conditioner_if #(.N_KEYS(N)) bus ();

  key_conditioner #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (20'd5),
    .HOLD_CYCLES     (27'd20),
    .REPEAT_CYCLES   (27'd8),
    .CNT_W           (27)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int kind, input int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.ch   = ch;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] outs();
    return {12'd0, bus.pressed, bus.press_p, bus.release_p, bus.long_p, bus.repeat_p};
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] e_pp, e_rp, e_lp, e_xp;
    ev_t keep[$];
    if (mon_en) begin
      e_pp = '0; e_rp = '0; e_lp = '0; e_xp = '0;
      keep = {};
      foreach (sb[i]) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            EV_PRESS:   begin e_pp[sb[i].ch] = 1'b1; exp_pressed[sb[i].ch] = 1'b1; end
            EV_RELEASE: begin e_rp[sb[i].ch] = 1'b1; exp_pressed[sb[i].ch] = 1'b0; end
            EV_LONG:    e_lp[sb[i].ch] = 1'b1;
            default:    e_xp[sb[i].ch] = 1'b1;
          endcase
        end else begin
          keep.push_back(sb[i]);
        end
      end
      sb = keep;
      check("outputs{pressed,press,release,long,repeat}", outs(),
            {12'd0, exp_pressed, e_pp, e_rp, e_lp, e_xp});
    end
  end

  initial begin
    int c;
    bus.key_n     = '1;
    bus.repeat_en = '0;
    rst_n         = 1'b0;
    step(3);
    check("reset_state", outs(), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(4);

    // Long hold on key 1 without repeat, then release.
    c = cyc;
    bus.key_n[1] = 1'b0;
    push(c + LAT, EV_PRESS, 1);
    push(c + LAT + HOLD, EV_LONG, 1);
    step(100);
    bus.key_n[1] = 1'b1;
    push(cyc + LAT, EV_RELEASE, 1);
    step(15);

    // Glitch shorter than the debounce window on key 2.
    bus.key_n[2] = 1'b0;
    step(3);
    bus.key_n[2] = 1'b1;
    step(15);

    // Auto-repeat on key 1; final repeat threshold coincides with the release.
    bus.repeat_en = 4'b0010;
    c = cyc;
    bus.key_n[1] = 1'b0;
    push(c + LAT, EV_PRESS, 1);
    push(c + LAT + HOLD, EV_LONG, 1);
    for (int k = 1; k <= 4; k++) push(c + LAT + HOLD + k * REP, EV_REPEAT, 1);
    step(60);
    bus.key_n[1] = 1'b1;
    push(cyc + LAT, EV_RELEASE, 1);
    step(20);

    // Short press on key 2.
    c = cyc;
    bus.key_n[2] = 1'b0;
    push(c + LAT, EV_PRESS, 2);
    step(12);
    bus.key_n[2] = 1'b1;
    push(cyc + LAT, EV_RELEASE, 2);
    step(20);

    // Keys 1 and 2 together; key 1 released exactly at its hold threshold.
    c = cyc;
    bus.key_n[2:1] = 2'b00;
    push(c + LAT, EV_PRESS, 1);
    push(c + LAT, EV_PRESS, 2);
    push(c + LAT + HOLD, EV_LONG, 2);
    step(HOLD);
    bus.key_n[1] = 1'b1;
    push(cyc + LAT, EV_RELEASE, 1);
    step(20);
    bus.key_n[2] = 1'b1;
    push(cyc + LAT, EV_RELEASE, 2);
    step(20);

    // Reset while key 0 sits in LONG; it must come back as a fresh press.
    c = cyc;
    bus.key_n[0] = 1'b0;
    push(c + LAT, EV_PRESS, 0);
    push(c + LAT + HOLD, EV_LONG, 0);
    step(35);
    rst_n = 1'b0;
    sb.delete();
    exp_pressed = '0;
    #1;
    check("async_reset_outputs", outs(), 32'd0);
    step(1);
    check("in_reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    c = cyc;
    push(c + LAT, EV_PRESS, 0);
    push(c + LAT + HOLD, EV_LONG, 0);
    step(30);
    bus.key_n[0] = 1'b1;
    push(cyc + LAT, EV_RELEASE, 0);
    step(15);

    check("scoreboard_drained", sb.size(), 32'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
